// File: rtl/fifo_wr_ptr_full.sv
// Async FIFO write-side pointer, Gray publisher and full/level status.
// Optional: define FIFO_OVF_DETECT_EN to build the sticky OVERFLOW flag.
module fifo_wr_ptr_full #(
  parameter int unsigned ADDR_WIDTH   = 3,
  parameter int unsigned AF_THRESHOLD = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  W_INC,
  input  logic [ADDR_WIDTH:0]   RQ2_PTR,
  output logic [ADDR_WIDTH-1:0] W_ADDR,
  output logic                  W_EN,
  output logic [ADDR_WIDTH:0]   W_PTR,
  output logic                  FULL,
  output logic                  ALMOST_FULL,
  output logic [ADDR_WIDTH:0]   W_LEVEL,
  output logic                  OVERFLOW
);

  localparam int unsigned PW = ADDR_WIDTH + 1;
  // Inverting the top two Gray bits of the read pointer gives the full pattern.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  logic [PW-1:0] wbin_q, wbin_next;
  logic [PW-1:0] gray_q, gray_next;
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] level_q, level_next;
  logic          full_q, full_next;
  logic          af_q, af_next;
  logic          accept;

  assign accept = W_INC & ~full_q & ~RST;

  // Next-state: pointer advance, Gray conversion, status from next pointer.
  always_comb begin
    wbin_next  = wbin_q;
    gray_next  = gray_q;
    rbin_sync  = '0;
    level_next = '0;
    full_next  = 1'b0;
    af_next    = 1'b0;
    if (accept) begin
      wbin_next = wbin_q + PW'(1);
    end
    gray_next = wbin_next ^ (wbin_next >> 1);
    for (int i = 0; i < int'(PW); i++) begin
      rbin_sync[i] = ^(RQ2_PTR >> i);
    end
    level_next = wbin_next - rbin_sync;
    full_next  = (gray_next == (RQ2_PTR ^ FULL_MASK));
    af_next    = (level_next >= PW'(AF_THRESHOLD));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wbin_q  <= '0;
      gray_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
    end else begin
      wbin_q  <= wbin_next;
      gray_q  <= gray_next;
      level_q <= level_next;
      full_q  <= full_next;
      af_q    <= af_next;
    end
  end

`ifdef FIFO_OVF_DETECT_EN
  logic ovf_q;

  // Sticky until reset: any write attempt while full.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ovf_q <= 1'b0;
    end else if (W_INC && full_q) begin
      ovf_q <= 1'b1;
    end
  end

  assign OVERFLOW = ovf_q;
`else
  assign OVERFLOW = 1'b0;
`endif

  assign W_EN        = accept;
  assign W_ADDR      = wbin_q[ADDR_WIDTH-1:0];
  assign W_PTR       = gray_q;
  assign FULL        = full_q;
  assign ALMOST_FULL = af_q;
  assign W_LEVEL     = level_q;

endmodule

// File: tb/tb_fifo_wr_ptr_full.sv
// Directed bench for fifo_wr_ptr_full with a reference model feeding a scoreboard queue.
module tb_fifo_wr_ptr_full;

  localparam int unsigned AW  = 3;
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned AFT = 6;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          W_INC = 1'b0;
  logic [PW-1:0] RQ2_PTR = '0;
  logic [AW-1:0] W_ADDR;
  logic          W_EN;
  logic [PW-1:0] W_PTR;
  logic          FULL;
  logic          ALMOST_FULL;
  logic [PW-1:0] W_LEVEL;
  logic          OVERFLOW;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [PW-1:0] ptr;
    logic [AW-1:0] addr;
    logic          full;
    logic          af;
    logic [PW-1:0] lvl;
    logic          ovf;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [PW-1:0] m_wbin = '0;
  logic          m_full = 1'b0;
  logic          m_ovf  = 1'b0;

`ifdef FIFO_OVF_DETECT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  fifo_wr_ptr_full #(.ADDR_WIDTH(AW), .AF_THRESHOLD(AFT)) dut (
    .CLK(CLK), .RST(RST), .W_INC(W_INC), .RQ2_PTR(RQ2_PTR),
    .W_ADDR(W_ADDR), .W_EN(W_EN), .W_PTR(W_PTR), .FULL(FULL),
    .ALMOST_FULL(ALMOST_FULL), .W_LEVEL(W_LEVEL), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, predict its outcome, then compare after the edge.
  task automatic step(input logic inc, input logic [PW-1:0] rq, input logic rst);
    exp_t e;
    logic [PW-1:0] lvl;
    exp_t got;
    W_INC = inc; RQ2_PTR = rq; RST = rst;
    #1;
    chk("w_en", 32'(W_EN), 32'(inc & ~m_full & ~rst));
    if (rst) begin
      m_wbin = '0; m_full = 1'b0; m_ovf = 1'b0; lvl = '0;
      e.af = 1'b0;
    end else begin
      if (inc && m_full && OVF_EN) m_ovf = 1'b1;
      if (inc && !m_full) m_wbin = m_wbin + PW'(1);
      lvl    = m_wbin - g2b(rq);
      m_full = (lvl == PW'(1 << AW));
      e.af   = (32'(lvl) >= AFT);
    end
    e.ptr  = m_wbin ^ (m_wbin >> 1);
    e.addr = m_wbin[AW-1:0];
    e.full = m_full;
    e.lvl  = lvl;
    e.ovf  = m_ovf;
    sb.push_back(e);
    @(posedge CLK); #1;
    got = sb.pop_front();
    chk("w_ptr",       32'(W_PTR),       32'(got.ptr));
    chk("w_addr",      32'(W_ADDR),      32'(got.addr));
    chk("full",        32'(FULL),        32'(got.full));
    chk("almost_full", 32'(ALMOST_FULL), 32'(got.af));
    chk("w_level",     32'(W_LEVEL),     32'(got.lvl));
    chk("overflow",    32'(OVERFLOW),    32'(got.ovf));
  endtask

  initial begin
    logic [PW-1:0] gseq [8];
    gseq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};

    @(posedge CLK); #1;
    step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b1);

    // Fill from empty; Gray sequence and full after eighth write
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'h0, 1'b0);
      chk("gray_seq", 32'(W_PTR), 32'(gseq[i]));
    end
    chk("full_after_8", 32'(FULL), 32'd1);
    chk("level_after_8", 32'(W_LEVEL), 32'd8);

    // Writes while full are rejected
    step(1'b1, 4'h0, 1'b0);
    step(1'b1, 4'h0, 1'b0);
    chk("ptr_hold", 32'(W_PTR), 32'hC);
    chk("ovf_build", 32'(OVERFLOW), 32'(OVF_EN));

    // Read seen (gray 3 = bin 2); write in the same cycle still rejected
    step(1'b1, 4'h3, 1'b0);
    chk("lvl_after_read", 32'(W_LEVEL), 32'd6);
    step(1'b1, 4'h3, 1'b0);
    chk("lvl_after_write", 32'(W_LEVEL), 32'd7);
    step(1'b0, 4'h3, 1'b0);

    // Wrap: fill, drain fully (gray C = bin 8), fill again
    step(1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 4'h0, 1'b0);
    step(1'b0, 4'hC, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'hC, 1'b0);
      if (i == 6) chk("no_full_at_15", 32'(FULL), 32'd0);
    end
    chk("wrap_ptr", 32'(W_PTR), 32'h0);
    chk("wrap_full", 32'(FULL), 32'd1);

    // Reset overrides a write request
    step(1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 4'h0, 1'b0);
    step(1'b1, 4'h0, 1'b1);
    chk("rst_level", 32'(W_LEVEL), 32'd0);

    // Write and read pointer step together at level 7
    for (int i = 0; i < 7; i++) step(1'b1, 4'h0, 1'b0);
    step(1'b1, 4'h1, 1'b0);
    chk("simul_level", 32'(W_LEVEL), 32'd7);
    chk("simul_full", 32'(FULL), 32'd0);
    step(1'b1, 4'h1, 1'b0);
    step(1'b1, 4'h1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
